// File: rtl/msb_pkg.sv
// msb_pkg: shared types and helpers for the MSB-position stimulus source.
//   state_t            - transmitter FSM states (IDLE, EMIT)
//   LFSR_TAPS          - tap mask for the 64-bit Fibonacci LFSR (taps 64,63,61,60)
//   LFSR_SEED_DEFAULT  - default non-zero LFSR reset value
//   pos_to_onehot(p)   - word with only bit p-1 set (0 for p == 0)
//   pos_to_mask(p)     - mask of the bits strictly below bit p-1
//   lfsr_step(s)       - one shift-left step of the LFSR
package msb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int unsigned LFSR_W            = 64;
  localparam logic [63:0] LFSR_TAPS         = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LFSR_SEED_DEFAULT = 64'hACE1_2468_1357_BDF9;

  function automatic logic [63:0] pos_to_onehot(input int unsigned p);
    logic [63:0] w_one;
    w_one = '0;
    if (p >= 1 && p <= LFSR_W) begin
      w_one = 64'd1 << (p - 1);
    end
    return w_one;
  endfunction

  function automatic logic [63:0] pos_to_mask(input int unsigned p);
    logic [63:0] w_mask;
    w_mask = '0;
    if (p >= 2 && p <= LFSR_W) begin
      w_mask = (64'd1 << (p - 1)) - 64'd1;
    end
    return w_mask;
  endfunction

  // Feedback is the XOR of the tapped bits, shifted in at bit 0.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/msb_word_gen.sv
// msb_word_gen: combinational word builder.
//   i_pos  - 1-based MSB position (0 = all-zero word)
//   i_lfsr - low LFSR bits used as fill below the MSB
//   o_word - generated word: bit i_pos-1 set, nothing above it,
//            LFSR bits (or zeros) below it
module msb_word_gen
  import msb_pkg::*;
#(
  parameter int unsigned DW_IN       = 64,
  parameter int unsigned PW          = 8,
  parameter bit          FILL_RANDOM = 1'b1
) (
  input  logic [PW-1:0]    i_pos,
  input  logic [DW_IN-1:0] i_lfsr,
  output logic [DW_IN-1:0] o_word
);

  logic [63:0] w_onehot;
  logic [63:0] w_mask;

  always_comb begin
    w_onehot = pos_to_onehot(32'(i_pos));
    w_mask   = pos_to_mask(32'(i_pos));
    o_word   = w_onehot[DW_IN-1:0];
    if (FILL_RANDOM) begin
      o_word = o_word | (i_lfsr & w_mask[DW_IN-1:0]);
    end
  end

endmodule

// File: rtl/msb_transmitter.sv
// msb_transmitter: emits words whose highest set bit sits at a commanded
// 1-based position, tagged with that position, for self-checking an MSB
// receiver.
//   clk, rst             - clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready  - command handshake
//   cmd_pos              - start position 0..DW_IN (larger values rejected)
//   cmd_count            - number of words (0 = accepted, nothing emitted)
//   cmd_sweep            - position increments (DW_IN wraps to 0) per word
//   out_valid/out_ready  - word handshake; word held while out_ready is low
//   out_data, out_pos    - generated word and its expected MSB position
//   busy                 - burst in progress
//   err                  - one-cycle pulse after a rejected command
module msb_transmitter
  import msb_pkg::*;
#(
  parameter int unsigned DW_IN       = 64,
  parameter int unsigned PW          = 8,
  parameter bit          FILL_RANDOM = 1'b1,
  parameter logic [63:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [PW-1:0]    cmd_pos,
  input  logic [PW-1:0]    cmd_count,
  input  logic             cmd_sweep,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW_IN-1:0] out_data,
  output logic [PW-1:0]    out_pos,
  output logic             busy,
  output logic             err
);

  localparam logic [PW-1:0] DW_POS = PW'(DW_IN);

  state_t             r_state;
  state_t             w_state_next;
  logic [PW-1:0]      r_remaining;
  logic [PW-1:0]      r_cur_pos;
  logic               r_sweep;
  logic [63:0]        r_lfsr;
  logic [DW_IN-1:0]   r_out_data;
  logic [PW-1:0]      r_out_pos;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_err;
  logic               r_cmd_ready;

  logic               w_accept;
  logic               w_reject;
  logic               w_start;
  logic               w_xfer;
  logic               w_last;
  logic [PW-1:0]      w_next_pos;
  logic [PW-1:0]      w_gen_pos;
  logic [63:0]        w_lfsr_next;
  logic [63:0]        w_gen_lfsr;
  logic [DW_IN-1:0]   w_word;

  // Outputs are registered, so the generator is fed the values that will be
  // current in the next cycle: the command's position and the present LFSR
  // when a burst starts, the advanced position and stepped LFSR after a
  // transfer.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_start      = 1'b0;
    w_xfer       = 1'b0;
    w_last       = 1'b0;
    w_lfsr_next  = lfsr_step(r_lfsr);
    w_next_pos   = r_cur_pos;
    if (r_sweep) begin
      w_next_pos = (r_cur_pos == DW_POS) ? '0 : r_cur_pos + 1'b1;
    end
    w_gen_pos  = w_next_pos;
    w_gen_lfsr = w_lfsr_next;

    case (r_state)
      IDLE: begin
        w_accept   = cmd_valid && r_cmd_ready;
        w_gen_pos  = cmd_pos;
        w_gen_lfsr = r_lfsr;
        if (w_accept) begin
          if (cmd_pos > DW_POS) begin
            w_reject = 1'b1;
          end else if (cmd_count != '0) begin
            w_start      = 1'b1;
            w_state_next = EMIT;
          end
        end
      end
      EMIT: begin
        w_xfer = r_out_valid && out_ready;
        w_last = w_xfer && (r_remaining == PW'(1));
        if (w_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  msb_word_gen #(
    .DW_IN       (DW_IN),
    .PW          (PW),
    .FILL_RANDOM (FILL_RANDOM)
  ) u_word_gen (
    .i_pos  (w_gen_pos),
    .i_lfsr (w_gen_lfsr[DW_IN-1:0]),
    .o_word (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_cur_pos   <= '0;
      r_sweep     <= 1'b0;
      r_lfsr      <= LFSR_SEED;
      r_out_data  <= '0;
      r_out_pos   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_err       <= w_reject;
      r_cmd_ready <= (w_state_next == IDLE);
      if (w_start) begin
        r_remaining <= cmd_count;
        r_cur_pos   <= cmd_pos;
        r_sweep     <= cmd_sweep;
        r_out_data  <= w_word;
        r_out_pos   <= cmd_pos;
        r_out_valid <= 1'b1;
        r_busy      <= 1'b1;
      end else if (w_xfer) begin
        r_lfsr      <= w_lfsr_next;
        r_remaining <= r_remaining - 1'b1;
        r_cur_pos   <= w_next_pos;
        if (w_last) begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end else begin
          r_out_data <= w_word;
          r_out_pos  <= w_next_pos;
        end
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_pos   = r_out_pos;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_msb_transmitter.sv
// Bench for msb_transmitter: one instance with LFSR fill, one with zero
// fill, driven by the same commands. A reference LFSR/word model fills a
// scoreboard when commands are issued; a negedge monitor pops it on
// transfers and also recomputes the MSB position of every word.
module tb_msb_transmitter;

  localparam logic [63:0] SEED = 64'hACE1_2468_1357_BDF9;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_pos;
  logic [7:0]  cmd_count;
  logic        cmd_sweep;
  logic        out_ready;

  logic        r_cmd_ready, r_out_valid, r_busy, r_err;
  logic [63:0] r_out_data;
  logic [7:0]  r_out_pos;
  logic        z_cmd_ready, z_out_valid, z_busy, z_err;
  logic [63:0] z_out_data;
  logic [7:0]  z_out_pos;

  always #5 clk = ~clk;

  msb_transmitter #(
    .DW_IN       (64),
    .PW          (8),
    .FILL_RANDOM (1'b1),
    .LFSR_SEED   (SEED)
  ) u_dut_r (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (r_cmd_ready),
    .cmd_pos   (cmd_pos),
    .cmd_count (cmd_count),
    .cmd_sweep (cmd_sweep),
    .out_valid (r_out_valid),
    .out_ready (out_ready),
    .out_data  (r_out_data),
    .out_pos   (r_out_pos),
    .busy      (r_busy),
    .err       (r_err)
  );

  msb_transmitter #(
    .DW_IN       (64),
    .PW          (8),
    .FILL_RANDOM (1'b0),
    .LFSR_SEED   (SEED)
  ) u_dut_z (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (z_cmd_ready),
    .cmd_pos   (cmd_pos),
    .cmd_count (cmd_count),
    .cmd_sweep (cmd_sweep),
    .out_valid (z_out_valid),
    .out_ready (out_ready),
    .out_data  (z_out_data),
    .out_pos   (z_out_pos),
    .busy      (z_busy),
    .err       (z_err)
  );

  typedef struct {
    logic [7:0]  pos;
    logic [63:0] word_r;
    logic [63:0] word_z;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] m_lfsr;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [63:0] sweep_words[4] = '{64'h2000_0000_0000_0000, 64'h4000_0000_0000_0000,
                                  64'h8000_0000_0000_0000, 64'h0};
  logic [7:0]  sweep_pos[4]   = '{8'd62, 8'd63, 8'd64, 8'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_step(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  function automatic logic [63:0] m_word(input int p, input logic [63:0] l, input bit fill);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      if (i + 1 == p) w[i] = 1'b1;
      else if (fill && (i + 1 < p)) w[i] = l[i];
    end
    return w;
  endfunction

  function automatic int msb_of(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) begin
      if (d[i]) return i + 1;
    end
    return 0;
  endfunction

  // Output monitor: every valid word must match the scoreboard head (which
  // only advances on a transfer, so stalled words must also hold).
  always @(negedge clk) begin
    if (!rst && (r_out_valid || z_out_valid)) begin
      chk("valid_pair", 64'(z_out_valid), 64'(r_out_valid));
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word: observed out_valid with pos %0d, expected no word", r_out_pos);
      end
      if (sb.size() != 0) begin
        mon_e = sb[0];
        chk("pos_r", 64'(r_out_pos), 64'(mon_e.pos));
        chk("pos_z", 64'(z_out_pos), 64'(mon_e.pos));
        chk("data_r", r_out_data, mon_e.word_r);
        chk("data_z", z_out_data, mon_e.word_z);
        chk("msb_r", 64'(msb_of(r_out_data)), 64'(r_out_pos));
        chk("busy_r", 64'(r_busy), 64'd1);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send_cmd(input int unsigned pos, input int unsigned count, input bit sweep);
    int unsigned k;
    int unsigned p;
    logic [63:0] l;
    k = 0;
    while (!r_cmd_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("cmd_ready_wait", 64'(r_cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_pos   = 8'(pos);
    cmd_count = 8'(count);
    cmd_sweep = sweep;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (pos <= 64 && count > 0) begin
      p = pos;
      l = m_lfsr;
      for (int unsigned i = 0; i < count; i++) begin
        sb.push_back('{pos: 8'(p), word_r: m_word(int'(p), l, 1'b1), word_z: m_word(int'(p), l, 1'b0)});
        l = m_step(l);
        if (sweep) p = (p == 64) ? 0 : p + 1;
      end
      m_lfsr = l;
    end
  endtask

  task automatic wait_done(input bit rnd);
    int unsigned k;
    k = 0;
    while ((r_busy || sb.size() != 0) && k < 1000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    chk("burst_end_busy", 64'(r_busy), 64'd0);
    chk("burst_end_sb", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_pos   = '0;
    cmd_count = '0;
    cmd_sweep = 1'b0;
    out_ready = 1'b1;
    m_lfsr    = SEED;

    #12;
    chk("rst_cmd_ready", 64'(r_cmd_ready), 64'd0);
    chk("rst_out_valid", 64'(r_out_valid), 64'd0);
    chk("rst_out_data", r_out_data, 64'd0);
    chk("rst_out_pos", 64'(r_out_pos), 64'd0);
    chk("rst_busy", 64'(r_busy), 64'd0);
    chk("rst_err", 64'(r_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 64'(r_cmd_ready), 64'd1);

    // Single top-position word, valid in the cycle after acceptance only.
    send_cmd(64, 1, 1'b0);
    chk("t1_valid", 64'(z_out_valid), 64'd1);
    chk("t1_busy", 64'(z_busy), 64'd1);
    chk("t1_cmd_ready", 64'(z_cmd_ready), 64'd0);
    chk("t1_data_z", z_out_data, 64'h8000_0000_0000_0000);
    chk("t1_pos_z", 64'(z_out_pos), 64'd64);
    @(posedge clk); #1;
    chk("t1_valid_drop", 64'(z_out_valid), 64'd0);
    chk("t1_busy_drop", 64'(z_busy), 64'd0);
    chk("t1_cmd_ready_back", 64'(z_cmd_ready), 64'd1);

    // Sweep across the wrap, one word per cycle.
    send_cmd(62, 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", 64'(z_out_valid), 64'd1);
      chk("t2_pos", 64'(z_out_pos), 64'(sweep_pos[i]));
      chk("t2_data", z_out_data, sweep_words[i]);
      @(posedge clk); #1;
    end
    chk("t2_end_valid", 64'(z_out_valid), 64'd0);

    // Out-of-range position is rejected with a single err pulse.
    send_cmd(65, 1, 1'b0);
    chk("t3_err", 64'(r_err), 64'd1);
    chk("t3_valid", 64'(r_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t3_err_clear", 64'(r_err), 64'd0);
    chk("t3_cmd_ready", 64'(r_cmd_ready), 64'd1);
    chk("t3_valid2", 64'(r_out_valid), 64'd0);

    // Zero count: accepted silently.
    send_cmd(10, 0, 1'b0);
    chk("t4_err", 64'(r_err), 64'd0);
    chk("t4_valid", 64'(r_out_valid), 64'd0);
    chk("t4_cmd_ready", 64'(r_cmd_ready), 64'd1);
    @(posedge clk); #1;
    chk("t4_valid2", 64'(r_out_valid), 64'd0);

    // Random stalls; the following command exposes the LFSR step count.
    send_cmd(8, 16, 1'b0);
    wait_done(1'b1);
    send_cmd(30, 1, 1'b0);
    wait_done(1'b0);

    // Reset in the middle of a burst.
    send_cmd(20, 10, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_word3_valid", 64'(r_out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid_r", 64'(r_out_valid), 64'd0);
    chk("t6_rst_busy_r", 64'(r_busy), 64'd0);
    chk("t6_rst_valid_z", 64'(z_out_valid), 64'd0);
    sb.delete();
    m_lfsr = SEED;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_cmd(10, 1, 1'b0);
    chk("t6_seed_word_r", r_out_data, 64'h0000_0000_0000_03F9);
    chk("t6_seed_word_z", z_out_data, 64'h0000_0000_0000_0200);
    wait_done(1'b0);

    // Random sweeps and fixed-position bursts with random back-pressure.
    for (int i = 0; i < 6; i++) begin
      send_cmd($urandom_range(0, 64), $urandom_range(1, 70), 1'b1);
      wait_done(1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      send_cmd($urandom_range(0, 64), $urandom_range(1, 12), 1'b0);
      wait_done(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
